// File: rtl/img_hist_eq_if.sv
// ------------------------------------------------------------------
// axi4_stream_if / img_lut_ctrl_if : video stream and LUT write bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface axi4_stream_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic [USER_W-1:0]     tuser;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                  output tready);
endinterface

interface img_lut_ctrl_if #(
  parameter int PX_W = 10
) ();
  logic [PX_W-1:0] orig_px;
  logic [PX_W-1:0] mod_px;
  logic            wr_stb;

  modport master (output orig_px, mod_px, wr_stb);
  modport slave  (input  orig_px, mod_px, wr_stb);
endinterface

`default_nettype wire

// File: rtl/img_hist_eq.sv
// ------------------------------------------------------------------
// img_hist_eq : per-frame luma histogram and CDF-based LUT writer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module img_hist_eq #(
  parameter int PX_WIDTH    = 10,
  parameter int FRAME_RES_X = 1920,
  parameter int FRAME_RES_Y = 1080
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           hist_eq_en_i,
  axi4_stream_if.slave   video_i,
  axi4_stream_if.master  video_o,
  img_lut_ctrl_if.master lut_ctrl_o,
  output logic           frame_done_o
);

  localparam int     TOTAL   = FRAME_RES_X * FRAME_RES_Y;
  localparam int     CNT_W   = $clog2(TOTAL + 1);
  localparam int     CDF_W   = CNT_W + 1;
  localparam int     BINS    = 2 ** PX_WIDTH;
  localparam int     MAX_PX  = BINS - 1;
  localparam longint SCALE_L = ((longint'(MAX_PX) << 16) + longint'(TOTAL / 2)) / longint'(TOTAL);
  localparam int     SCALE_W = PX_WIDTH + 17;
  localparam int     PROD_W  = CDF_W + SCALE_W;
  localparam int     LINE_W  = $clog2(FRAME_RES_Y + 1);
  localparam int     STEP_W  = PX_WIDTH + 1;
  localparam logic [SCALE_W-1:0] SCALE = SCALE_W'(SCALE_L);

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACCUM    = 2'd2,
    ST_CALC     = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [STEP_W-1:0]    step;
  logic [LINE_W-1:0]    line_cnt;
  logic                 en_q;
  logic                 in_ready, accept, count_beat;
  logic [PX_WIDTH-1:0]  beat_bin;

  logic [CNT_W-1:0]     hist_mem [BINS];
  logic [CNT_W-1:0]     rd_data;
  logic [PX_WIDTH-1:0]  rd_addr, rd_addr_q;
  logic                 wr_en;
  logic [PX_WIDTH-1:0]  wr_addr;
  logic [CNT_W-1:0]     wr_data;

  logic                 s1_vld, s2_vld;
  logic [PX_WIDTH-1:0]  s1_bin, s2_bin;
  logic [CNT_W-1:0]     s2_cnt;
  logic [CNT_W-1:0]     bin_val, inc_val;

  logic [CDF_W-1:0]     cdf, cdf_sum;
  logic [CDF_W:0]       cdf_wide;
  logic [PROD_W-1:0]    prod, scaled;
  logic [PX_WIDTH-1:0]  mod_val;
  logic                 calc_wr;
  logic [PX_WIDTH-1:0]  calc_bin;

  assign in_ready   = (!video_o.tvalid || video_o.tready) &&
                      (state == ST_WAIT_SOF || state == ST_ACCUM);
  assign video_i.tready = in_ready;
  assign accept     = video_i.tvalid && in_ready;
  assign count_beat = accept && (state == ST_ACCUM || video_i.tuser[0]);
  assign beat_bin   = video_i.tdata[PX_WIDTH-1:0];

  // The previous increment lands in the RAM on the same edge this read samples, so bypass it
  assign bin_val  = (s2_vld && s2_bin == rd_addr_q) ? s2_cnt : rd_data;
  assign inc_val  = (&bin_val) ? bin_val : bin_val + 1'b1;

  assign cdf_wide = {1'b0, cdf} + {{(CDF_W + 1 - CNT_W){1'b0}}, bin_val};
  assign cdf_sum  = cdf_wide[CDF_W] ? {CDF_W{1'b1}} : cdf_wide[CDF_W-1:0];
  assign prod     = {{(PROD_W - CDF_W){1'b0}}, cdf_sum} * {{(PROD_W - SCALE_W){1'b0}}, SCALE};
  assign scaled   = prod >> 16;
  assign mod_val  = (scaled > PROD_W'(MAX_PX)) ? PX_WIDTH'(MAX_PX) : scaled[PX_WIDTH-1:0];

  assign calc_wr  = (state == ST_CALC) && (step != '0) && (step <= STEP_W'(BINS));
  assign calc_bin = PX_WIDTH'(step - 1'b1);

  always_comb begin
    state_nx = state;
    rd_addr  = beat_bin;
    wr_en    = 1'b0;
    wr_addr  = s1_bin;
    wr_data  = inc_val;
    case (state)
      ST_CLEAR:    if (step == STEP_W'(MAX_PX)) state_nx = ST_WAIT_SOF;
      ST_WAIT_SOF: if (accept && video_i.tuser[0]) state_nx = ST_ACCUM;
      ST_ACCUM:    if (accept && video_i.tlast && line_cnt == LINE_W'(FRAME_RES_Y - 1))
                     state_nx = ST_CALC;
      ST_CALC: begin
        rd_addr = step[PX_WIDTH-1:0];
        if (step == STEP_W'(BINS + 1)) state_nx = ST_WAIT_SOF;
      end
      default:     state_nx = ST_CLEAR;
    endcase
    if (s1_vld) begin
      wr_en   = 1'b1;
    end else if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = step[PX_WIDTH-1:0];
      wr_data = '0;
    end else if (calc_wr) begin
      wr_en   = 1'b1;
      wr_addr = calc_bin;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) hist_mem[wr_addr] <= wr_data;
    rd_data <= hist_mem[rd_addr];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_CLEAR;
      step       <= '0;
      line_cnt   <= '0;
      en_q       <= 1'b0;
      s1_vld     <= 1'b0;
      s1_bin     <= '0;
      s2_vld     <= 1'b0;
      s2_bin     <= '0;
      s2_cnt     <= '0;
      rd_addr_q  <= '0;
      cdf        <= '0;
      frame_done_o       <= 1'b0;
      lut_ctrl_o.wr_stb  <= 1'b0;
      lut_ctrl_o.orig_px <= '0;
      lut_ctrl_o.mod_px  <= '0;
    end else begin
      state <= state_nx;
      if ((state == ST_CLEAR || state == ST_CALC) && state_nx == state) step <= step + 1'b1;
      else                                                              step <= '0;

      if (state == ST_WAIT_SOF)                                line_cnt <= '0;
      else if (state == ST_ACCUM && accept && video_i.tlast)   line_cnt <= line_cnt + 1'b1;

      if (state == ST_ACCUM && state_nx == ST_CALC) en_q <= hist_eq_en_i;

      s1_vld    <= count_beat;
      s1_bin    <= beat_bin;
      s2_vld    <= s1_vld;
      s2_bin    <= s1_bin;
      s2_cnt    <= inc_val;
      rd_addr_q <= rd_addr;

      lut_ctrl_o.wr_stb <= 1'b0;
      frame_done_o      <= 1'b0;
      if (calc_wr) begin
        cdf                <= cdf_sum;
        lut_ctrl_o.wr_stb  <= en_q;
        lut_ctrl_o.orig_px <= calc_bin;
        lut_ctrl_o.mod_px  <= mod_val;
      end
      if (state == ST_CALC && state_nx != ST_CALC) begin
        cdf          <= '0;
        frame_done_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      video_o.tvalid <= 1'b0;
      video_o.tdata  <= '0;
      video_o.tstrb  <= '0;
      video_o.tkeep  <= '0;
      video_o.tlast  <= 1'b0;
      video_o.tuser  <= '0;
      video_o.tid    <= '0;
      video_o.tdest  <= '0;
    end else if (!video_o.tvalid || video_o.tready) begin
      video_o.tvalid <= accept;
      if (accept) begin
        video_o.tdata <= video_i.tdata;
        video_o.tstrb <= video_i.tstrb;
        video_o.tkeep <= video_i.tkeep;
        video_o.tlast <= video_i.tlast;
        video_o.tuser <= video_i.tuser;
        video_o.tid   <= video_i.tid;
        video_o.tdest <= video_i.tdest;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_img_hist_eq.sv
// ------------------------------------------------------------------
// tb_img_hist_eq : directed self-checking bench for img_hist_eq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_img_hist_eq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b1;
  logic frame_done;
  bit   bp_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  axi4_stream_if  #(.DATA_W(8)) vin  ();
  axi4_stream_if  #(.DATA_W(8)) vout ();
  img_lut_ctrl_if #(.PX_W(4))   lut  ();

  img_hist_eq #(.PX_WIDTH(4), .FRAME_RES_X(4), .FRAME_RES_Y(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .hist_eq_en_i (en),
    .video_i      (vin),
    .video_o      (vout),
    .lut_ctrl_o   (lut),
    .frame_done_o (frame_done)
  );

  logic [3:0] frame_px [16];
  logic [9:0] in_q[$], out_q[$];
  logic [3:0] wr_orig[$], wr_mod[$];
  int         done_cnt = 0;
  int         stb_while_ready = 0;
  logic       prev_acc = 1'b0;
  logic [9:0] prev_beat = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    vout.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      vout.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_acc)
        chk("latency", {21'd0, vout.tvalid, vout.tuser, vout.tlast, vout.tdata}, {21'd0, 1'b1, prev_beat});
      if (vin.tvalid && vin.tready)   in_q.push_back({vin.tuser, vin.tlast, vin.tdata});
      if (vout.tvalid && vout.tready) out_q.push_back({vout.tuser, vout.tlast, vout.tdata});
      if (lut.wr_stb) begin
        wr_orig.push_back(lut.orig_px);
        wr_mod.push_back(lut.mod_px);
        if (vin.tready) stb_while_ready++;
      end
      if (frame_done) done_cnt++;
      prev_acc  = vin.tvalid && vin.tready;
      prev_beat = {vin.tuser, vin.tlast, vin.tdata};
    end else begin
      prev_acc = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(logic [3:0] px, logic user, logic last);
    int n = 0;
    vin.tvalid = 1'b1;
    vin.tdata  = {4'h0, px};
    vin.tuser  = user;
    vin.tlast  = last;
    @(negedge clk);
    while (vin.tready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_pixels(int first, int last_i, int mid_user);
    for (int i = first; i <= last_i; i++)
      send_beat(frame_px[i], (i == 0) || (i == mid_user), (i % 4) == 3);
    vin.tvalid = 1'b0;
  endtask

  task automatic wait_clear(string tag);
    int n = 0;
    int bad = 0;
    @(negedge clk);
    while (vin.tready !== 1'b1 && n < 100) begin
      if (vout.tvalid !== 1'b0 || lut.wr_stb !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_clear_cycles"}, n, 16);
    chk({tag, "_clear_quiet"}, bad, 0);
    @(posedge clk); #1;
  endtask

  task automatic measure_calc(string tag);
    int n = 0;
    @(negedge clk);
    while (vin.tready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_calc_cycles"}, n, 18);
    chk({tag, "_done_at_exit"}, frame_done, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int exp_mod(int cdf);
    int v;
    v = (cdf * 61440) >>> 16;
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_lut(string tag, bit enabled);
    int hist [16];
    int cdf = 0;
    foreach (hist[k]) hist[k] = 0;
    for (int i = 0; i < 16; i++) hist[frame_px[i]]++;
    chk({tag, "_wr_count"}, wr_orig.size(), enabled ? 16 : 0);
    for (int k = 0; k < 16; k++) begin
      cdf += hist[k];
      if (k < wr_orig.size()) begin
        chk($sformatf("%s_orig%0d", tag, k), wr_orig[k], k);
        chk($sformatf("%s_mod%0d", tag, k), wr_mod[k], exp_mod(cdf));
      end
    end
    wr_orig.delete();
    wr_mod.delete();
  endtask

  task automatic check_video(string tag);
    chk({tag, "_beats"}, out_q.size(), in_q.size());
    for (int i = 0; i < in_q.size() && i < out_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), out_q[i], in_q[i]);
    in_q.delete();
    out_q.delete();
  endtask

  initial begin
    int d0;
    vin.tvalid = 1'b0;
    vin.tdata  = '0;
    vin.tuser  = '0;
    vin.tlast  = 1'b0;
    vin.tstrb  = '1;
    vin.tkeep  = '1;
    vin.tid    = '0;
    vin.tdest  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", vout.tvalid, 0);
    chk("rst_wr_stb", lut.wr_stb, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_tready", vin.tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear("init");

    // Frame A: every pixel at 5
    foreach (frame_px[i]) frame_px[i] = 4'd5;
    d0 = done_cnt;
    send_pixels(0, 15, -1);
    measure_calc("A");
    chk("A_done_once", done_cnt - d0, 1);
    check_lut("A", 1'b1);
    check_video("A");

    // Frame B: 8x2 / 8x9 interleaved, adjacent and two-apart repeats of the same bin
    frame_px = '{4'd2, 4'd2, 4'd9, 4'd2, 4'd9, 4'd9, 4'd2, 4'd9,
                 4'd2, 4'd2, 4'd2, 4'd9, 4'd9, 4'd9, 4'd2, 4'd9};
    d0 = done_cnt;
    send_pixels(0, 15, -1);
    measure_calc("B");
    chk("B_done_once", done_cnt - d0, 1);
    check_lut("B", 1'b1);
    check_video("B");

    // Frame C: identical, so bins must have been zeroed by the previous pass
    send_pixels(0, 15, -1);
    measure_calc("C");
    check_lut("C", 1'b1);
    check_video("C");

    // Frame D: disabled, different data
    foreach (frame_px[i]) frame_px[i] = 4'd15;
    en = 1'b0;
    d0 = done_cnt;
    send_pixels(0, 15, -1);
    measure_calc("D");
    en = 1'b1;
    chk("D_done_once", done_cnt - d0, 1);
    check_lut("D", 1'b0);
    check_video("D");

    // Frame E: stray beats before SOF, tuser in mid-frame, one pixel per bin
    send_beat(4'd0, 1'b0, 1'b0);
    send_beat(4'd0, 1'b0, 1'b1);
    vin.tvalid = 1'b0;
    foreach (frame_px[i]) frame_px[i] = 4'(i);
    send_pixels(0, 15, 7);
    measure_calc("E");
    check_lut("E", 1'b1);
    check_video("E");

    // Frame F: random back-pressure, then reset during the LUT pass
    foreach (frame_px[i]) frame_px[i] = 4'((i * 7) % 16);
    bp_en = 1'b1;
    send_pixels(0, 15, -1);
    bp_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_video("F");
    chk("F_writes_started", wr_orig.size() > 0, 1);
    for (int k = 0; k < wr_orig.size(); k++)
      chk($sformatf("F_partial_orig%0d", k), wr_orig[k], k);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("F_rst_wr_stb", lut.wr_stb, 0);
    chk("F_rst_tvalid", vout.tvalid, 0);
    chk("F_rst_tready", vin.tready, 0);
    chk("F_rst_done", frame_done, 0);
    wr_orig.delete();
    wr_mod.delete();
    in_q.delete();
    out_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("F");

    // Frame G: no LUT writes until the full frame is in
    foreach (frame_px[i]) frame_px[i] = 4'd3;
    send_pixels(0, 14, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("G_no_early_wr", wr_orig.size(), 0);
    send_pixels(15, 15, -1);
    measure_calc("G");
    check_lut("G", 1'b1);
    check_video("G");

    chk("stb_outside_calc", stb_while_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
